imm_extend_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational immediate sign extender. Sits between decode and the operand mux / branch-target adder.
- Extracts and extends immediates for I, D, B, CBZ and the wide-move family (MOVZ/MOVN/MOVK) to DATA_W bits.
- Optionally pre-scales branch offsets. Delivers results through a 2-stage valid/ready pipeline with flush, so decode can stall independently of execute.

---
 rtl/imm_extend_pipe_if.sv | 32 +++
 rtl/imm_extend_pipe.sv | 118 +++++++++++
 tb/tb_imm_extend_pipe.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if
//   Request/response bundle for imm_extend_pipe.
//   Request side:  in_valid, in_ready, in_imm26, in_ctrl, in_old.
//   Response side: out_valid, out_ready, out_imm, out_err.
//   Handshake: a beat transfers on a rising clock edge where valid && ready.
//   A producer holds valid and its payload stable until that edge. ready
//   never depends on valid in the same cycle.
//   master: upstream decode plus downstream consumer (drives requests, accepts results)
//   slave : the extender pipeline itself
interface imm_extend_pipe_if #(
    parameter int DATA_W = 64
) ();
    logic              in_valid;
    logic              in_ready;
    logic [25:0]       in_imm26;
    logic [2:0]        in_ctrl;
    logic [DATA_W-1:0] in_old;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic              out_err;

    modport master (
        output in_valid, in_imm26, in_ctrl, in_old, out_ready,
        input  in_ready, out_valid, out_imm, out_err
    );

    modport slave (
        input  in_valid, in_imm26, in_ctrl, in_old, out_ready,
        output in_ready, out_valid, out_imm, out_err
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Two-stage valid/ready pipeline that extracts and extends the immediate
//   for the I, D, B, CBZ and wide-move (MOVZ/MOVN/MOVK) formats to DATA_W bits.
//   S1 registers the raw request. S2 computes the result and registers it
//   as the output.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     flush  drops every in-flight entry, including a request offered this cycle
//     bus    imm_extend_pipe_if.slave (in_* request, out_* response)
//   Parameters:
//     DATA_W    result width, 32 or 64
//     SCALE_EN  1: B/CBZ offsets are shifted left by 2 (byte offset)
module imm_extend_pipe #(
    parameter int DATA_W   = 64,
    parameter bit SCALE_EN = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    input logic              flush,
    imm_extend_pipe_if.slave bus
);
    localparam bit NARROW = (DATA_W == 32);

    // S1 request register
    logic              s1_valid;
    logic [25:0]       s1_imm;
    logic [2:0]        s1_ctrl;
    logic [DATA_W-1:0] s1_old;

    // S2 (output) advances when it is empty or being drained this cycle.
    logic s2_adv;
    logic s1_load;
    assign s2_adv      = !bus.out_valid || bus.out_ready;
    // S1 can take a new beat when it is empty or its content moves into S2.
    assign bus.in_ready = !(s1_valid && bus.out_valid && !bus.out_ready);
    assign s1_load     = bus.in_valid && bus.in_ready;

    // Result computation from the S1 contents
    logic [1:0]        hw;
    logic [5:0]        sh;
    logic [DATA_W-1:0] movz_val;
    logic [DATA_W-1:0] hw_mask;
    logic [DATA_W-1:0] res;
    logic              err;

    assign hw       = s1_imm[22:21];
    assign sh       = {hw, 4'b0000};
    // Shifts past DATA_W simply fall off the top; the narrow hw[1] case is
    // flagged as an error below anyway.
    assign movz_val = {{(DATA_W-16){1'b0}}, s1_imm[20:5]} << sh;
    assign hw_mask  = {{(DATA_W-16){1'b0}}, 16'hFFFF} << sh;

    always_comb begin
        res = '0;
        err = 1'b0;
        case (s1_ctrl)
            3'b000: begin
                res = {{(DATA_W-12){1'b0}}, s1_imm[21:10]};
                if (s1_imm[22]) res = res << 12;
            end
            3'b001: res = {{(DATA_W-9){s1_imm[20]}}, s1_imm[20:12]};
            3'b010: begin
                res = {{(DATA_W-26){s1_imm[25]}}, s1_imm[25:0]};
                if (SCALE_EN) res = res << 2;
            end
            3'b011: begin
                res = {{(DATA_W-19){s1_imm[23]}}, s1_imm[23:5]};
                if (SCALE_EN) res = res << 2;
            end
            3'b100: res = movz_val;
            3'b101: res = ~movz_val;
            3'b110: res = (s1_old & ~hw_mask) | movz_val;
            default: begin
                res = '0;
                err = 1'b1;
            end
        endcase
        // A 32-bit result only has halfwords 0 and 1.
        if (NARROW && (s1_ctrl == 3'b100 || s1_ctrl == 3'b101 || s1_ctrl == 3'b110) && hw[1]) begin
            res = '0;
            err = 1'b1;
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_imm   <= '0;
            bus.out_err   <= 1'b0;
        end else if (flush) begin
            s1_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_imm <= res;
                    bus.out_err <= err;
                end
            end
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
            end
        end
    end

    // S1 payload: contents only matter while s1_valid is set, so no reset.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_imm  <= bus.in_imm26;
            s1_ctrl <= bus.in_ctrl;
            s1_old  <= bus.in_old;
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush64 = 1'b0;
    logic flush32 = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [64:0] exp_q64[$];
    logic [32:0] exp_q32[$];

    imm_extend_pipe_if #(.DATA_W(64)) v64 ();
    imm_extend_pipe_if #(.DATA_W(32)) v32 ();

    imm_extend_pipe #(.DATA_W(64), .SCALE_EN(1'b1)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64), .bus(v64.slave)
    );
    imm_extend_pipe #(.DATA_W(32), .SCALE_EN(1'b0)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32), .bus(v32.slave)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send64(input logic [2:0] c, input logic [25:0] i, input logic [63:0] old,
                          input logic err, input logic [63:0] imm);
        int n = 0;
        v64.in_valid = 1'b1;
        v64.in_ctrl  = c;
        v64.in_imm26 = i;
        v64.in_old   = old;
        @(negedge clk);
        while (!v64.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!v64.in_ready) chk("accept64_timeout", 65'd0, 65'd1);
        else exp_q64.push_back({err, imm});
        @(posedge clk);
        #1;
        v64.in_valid = 1'b0;
    endtask

    task automatic send32(input logic [2:0] c, input logic [25:0] i, input logic [31:0] old,
                          input logic err, input logic [31:0] imm);
        int n = 0;
        v32.in_valid = 1'b1;
        v32.in_ctrl  = c;
        v32.in_imm26 = i;
        v32.in_old   = old;
        @(negedge clk);
        while (!v32.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!v32.in_ready) chk("accept32_timeout", 65'd0, 65'd1);
        else exp_q32.push_back({err, imm});
        @(posedge clk);
        #1;
        v32.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q64.size() != 0 || exp_q32.size() != 0) && n < 100) begin
            n++;
            @(posedge clk);
        end
        #1;
        if (exp_q64.size() != 0 || exp_q32.size() != 0) chk("drain_timeout", 65'd0, 65'd1);
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (rst_n && v64.out_valid && v64.out_ready) begin
            logic [64:0] e;
            if (exp_q64.size() == 0) begin
                chk("unexpected_out64", {v64.out_err, v64.out_imm}, 65'h1_FFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q64.pop_front();
                chk("out64", {v64.out_err, v64.out_imm}, e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && v32.out_valid && v32.out_ready) begin
            logic [32:0] e;
            if (exp_q32.size() == 0) begin
                chk("unexpected_out32", {32'd0, v32.out_err, v32.out_imm}, 65'h1_FFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q32.pop_front();
                chk("out32", {32'd0, v32.out_err, v32.out_imm}, {32'd0, e});
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        v64.in_valid = 1'b0; v64.in_ctrl = '0; v64.in_imm26 = '0; v64.in_old = '0; v64.out_ready = 1'b1;
        v32.in_valid = 1'b0; v32.in_ctrl = '0; v32.in_imm26 = '0; v32.in_old = '0; v32.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        chk("rst_out_valid64", {64'd0, v64.out_valid}, 65'd0);
        chk("rst_out_imm64",   {1'b0, v64.out_imm}, 65'd0);
        chk("rst_out_err64",   {64'd0, v64.out_err}, 65'd0);
        chk("rst_out_valid32", {64'd0, v32.out_valid}, 65'd0);
        rst_n = 1'b1;
        chk("rst_in_ready64",  {64'd0, v64.in_ready}, 65'd1);

        // MOVZ hw=1, latency exactly 2 edges after acceptance
        send64(3'b100, 26'h224680, 64'd0, 1'b0, 64'h0000_0000_1234_0000);
        chk("lat_edge1_valid", {64'd0, v64.out_valid}, 65'd0);
        @(posedge clk); #1;
        chk("lat_edge2_valid", {64'd0, v64.out_valid}, 65'd1);
        chk("lat_edge2_imm",   {1'b0, v64.out_imm}, {1'b0, 64'h0000_0000_1234_0000});
        drain();

        // back-to-back directed vectors at full throughput
        send64(3'b110, 26'h5579A0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_ABCD_FFFF_FFFF);
        send64(3'b101, 26'h5579A0, 64'd0, 1'b0, 64'hFFFF_5432_FFFF_FFFF);
        send64(3'b010, 26'h3FFFFFF, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
        send64(3'b001, 26'h100000, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF00);
        send64(3'b000, 26'h7FFC00, 64'd0, 1'b0, 64'h0000_0000_00FF_F000);
        send64(3'b011, 26'h0800000, 64'd0, 1'b0, 64'hFFFF_FFFF_FFF0_0000);
        send64(3'b100, 26'h600020, 64'd0, 1'b0, 64'h0001_0000_0000_0000);
        send64(3'b111, 26'h1234567, 64'd0, 1'b1, 64'd0);
        send64(3'b000, 26'h0000400, 64'd0, 1'b0, 64'd1);
        drain();

        // backpressure: 4 back-to-back I requests, output stalled 3 cycles
        v64.out_ready = 1'b0;
        fork
            begin
                send64(3'b000, 26'h0000400, 64'd0, 1'b0, 64'd1);
                send64(3'b000, 26'h0000800, 64'd0, 1'b0, 64'd2);
                send64(3'b000, 26'h0000C00, 64'd0, 1'b0, 64'd3);
                send64(3'b000, 26'h0001000, 64'd0, 1'b0, 64'd4);
            end
            begin
                @(posedge clk);
                @(posedge clk); #1;
                chk("bp_in_ready_low", {64'd0, v64.in_ready}, 65'd0);
                chk("bp_hold_imm_a",   {v64.out_err, v64.out_imm}, 65'd1);
                @(posedge clk); #1;
                chk("bp_hold_imm_b",   {v64.out_err, v64.out_imm}, 65'd1);
                chk("bp_hold_valid",   {64'd0, v64.out_valid}, 65'd1);
                @(posedge clk); #1;
                v64.out_ready = 1'b1;
            end
        join
        drain();

        // flush with both stages full and a third request offered
        v64.out_ready = 1'b0;
        send64(3'b000, 26'h0001400, 64'd0, 1'b0, 64'd5);
        send64(3'b000, 26'h0001800, 64'd0, 1'b0, 64'd6);
        v64.in_valid = 1'b1; v64.in_ctrl = 3'b000; v64.in_imm26 = 26'h0001C00;
        flush64 = 1'b1;
        exp_q64.delete();
        @(posedge clk); #1;
        flush64 = 1'b0;
        v64.in_valid = 1'b0;
        chk("flush_out_valid", {64'd0, v64.out_valid}, 65'd0);
        chk("flush_in_ready",  {64'd0, v64.in_ready}, 65'd1);
        v64.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        // flush while empty: offered request is dropped even though in_ready=1
        v64.in_valid = 1'b1; v64.in_ctrl = 3'b000; v64.in_imm26 = 26'h0002400;
        flush64 = 1'b1;
        @(posedge clk); #1;
        flush64 = 1'b0;
        v64.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_drop_valid", {64'd0, v64.out_valid}, 65'd0);
        send64(3'b000, 26'h0002000, 64'd0, 1'b0, 64'd8);
        drain();

        // DATA_W=32, SCALE_EN=0 instance
        send32(3'b100, 26'h424680, 32'd0, 1'b1, 32'd0);
        send32(3'b111, 26'h0000400, 32'd0, 1'b1, 32'd0);
        send32(3'b100, 26'h224680, 32'd0, 1'b0, 32'h1234_0000);
        send32(3'b010, 26'h3FFFFFF, 32'd0, 1'b0, 32'hFFFF_FFFF);
        send32(3'b110, 26'h3579A0, 32'hFFFF_FFFF, 1'b0, 32'hABCD_FFFF);
        send32(3'b101, 26'h5579A0, 32'd0, 1'b1, 32'd0);
        drain();

        // reset mid-stream on the 32-bit pipe
        v32.out_ready = 1'b0;
        send32(3'b100, 26'h224680, 32'd0, 1'b0, 32'h1234_0000);
        send32(3'b000, 26'h0000400, 32'd0, 1'b0, 32'd1);
        rst_n = 1'b0;
        exp_q32.delete();
        @(posedge clk); #1;
        chk("midrst_out_valid", {64'd0, v32.out_valid}, 65'd0);
        chk("midrst_out_imm",   {33'd0, v32.out_imm}, 65'd0);
        rst_n = 1'b1;
        v32.out_ready = 1'b1;
        chk("midrst_in_ready",  {64'd0, v32.in_ready}, 65'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_stale",  {64'd0, v32.out_valid}, 65'd0);
        send32(3'b001, 26'h100000, 32'd0, 1'b0, 32'hFFFF_FF00);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
